// File: rtl/regbank_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: FSM state
// encodings, bank defaults and an index-width helper.
package regbank_write_arbiter_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_N_REGS = 8;

    typedef enum logic {
        ARB_ST_ARB  = 1'b0,
        ARB_ST_LOCK = 1'b1
    } arb_state_e;

    // Width needed to index n items; never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first set request
// found scanning upward from ptr, wrapping modulo N. ptr must be < N.
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [N-1:0] rot;
    logic [N-1:0] first;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot   = N'({req, req} >> ptr);
        first = rot & (-rot);
        grant = N'(({first, first} << ptr) >> N);
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin write-port arbiter with bounded lock in front of a register
// bank; registers the winner and drives one-hot write enables plus shared data.
module regbank_write_arbiter
    import regbank_write_arbiter_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int N_REGS   = DEF_N_REGS,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_LOCK = 4
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_lock,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REGS-1:0]         reg_write_vec,
    output logic [DATA_W-1:0]         reg_data,
    output logic                      addr_err,
    output logic                      locked
);

    localparam int PTR_W = idx_w(N_REQ);
    localparam int CNT_W = idx_w(MAX_LOCK + 1);

    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REGS-1:0]  reg_write_vec_q, reg_write_vec_d;
    logic [DATA_W-1:0]  reg_data_q, reg_data_d;
    logic               addr_err_q, addr_err_d;

    logic [N_REQ-1:0]   rr_grant;
    logic [N_REQ-1:0]   xfer;
    logic               any_xfer;
    logic [PTR_W-1:0]   win_idx;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;
    logic               win_lock;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] i);
        return (i == PTR_W'(N_REQ - 1)) ? '0 : i + PTR_W'(1);
    endfunction

    rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (rr_grant)
    );

    // Grant looks only at req and FSM registers, never at address or data.
    always_comb begin
        grant = '0;
        if (!reset) begin
            if (state_q == ARB_ST_ARB) grant = rr_grant;
            else                       grant = req & (N_REQ'(1) << owner_q);
        end
    end

    always_comb begin
        xfer     = req & grant;
        any_xfer = |xfer;
        win_idx  = '0;
        win_addr = '0;
        win_data = '0;
        win_lock = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (xfer[i]) begin
                win_idx  = PTR_W'(i);
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
                win_lock = req_lock[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_ST_ARB: begin
                if (any_xfer) begin
                    if (win_lock) begin
                        state_d = ARB_ST_LOCK;
                        owner_d = win_idx;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        ptr_d = next_ptr(win_idx);
                    end
                end
            end
            ARB_ST_LOCK: begin
                // Counter runs even while the owner idles, bounding the stall of others.
                cnt_d = cnt_q + CNT_W'(1);
                if ((any_xfer && !win_lock) || (cnt_d == CNT_W'(MAX_LOCK))) begin
                    state_d = ARB_ST_ARB;
                    ptr_d   = next_ptr(owner_q);
                    cnt_d   = '0;
                end
            end
            default: state_d = ARB_ST_ARB;
        endcase
    end

    always_comb begin
        reg_write_vec_d = '0;
        addr_err_d      = 1'b0;
        reg_data_d      = reg_data_q;
        if (any_xfer) begin
            reg_data_d = win_data;
            if ({1'b0, win_addr} < (ADDR_W + 1)'(N_REGS)) reg_write_vec_d = N_REGS'(1) << win_addr;
            else                                          addr_err_d      = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q         <= ARB_ST_ARB;
            ptr_q           <= '0;
            owner_q         <= '0;
            cnt_q           <= '0;
            reg_write_vec_q <= '0;
            reg_data_q      <= '0;
            addr_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            owner_q         <= owner_d;
            cnt_q           <= cnt_d;
            reg_write_vec_q <= reg_write_vec_d;
            reg_data_q      <= reg_data_d;
            addr_err_q      <= addr_err_d;
        end
    end

    assign reg_write_vec = reg_write_vec_q;
    assign reg_data      = reg_data_q;
    assign addr_err      = addr_err_q;
    assign locked        = (state_q == ARB_ST_LOCK);

endmodule
